net_dataplane_top: RTL and testbench
====================================

// Module: net_dataplane_top
// PURPOSE
//  PL dataplane top: AXI4-Lite slave register file (control/status/statistics) plus AXI-Stream RX sink.
//  Sits behind the Zynq PS GP port; PS enables RX, ingress stream beats are consumed and counted.
//  Single clock domain; no buffering of stream payload beyond last-beat capture.
// PARAMETERS
//  DATA_WIDTH       64  AXI-Stream tdata width (multiple of 8, >=32); tkeep = DATA_WIDTH/8
//  AXIL_ADDR_WIDTH  32  AXI4-Lite address width (only bits [7:2] decoded)
// PORTS
//  clk      in   1             system clock
//  rst      in   1             reset; one clock; reset is synchronous and active-high
//  AWADDR/AWPROT/AWVALID in AXIL_ADDR_WIDTH/3/1; AWREADY out 1   write address channel (AWPROT ignored)
//  WDATA/WSTRB/WVALID    in 32/4/1;  WREADY out 1                write data channel
//  BREADY in 1; BVALID out 1; BRESP out 2                        write response
//  ARADDR/ARPROT/ARVALID in AXIL_ADDR_WIDTH/3/1; ARREADY out 1   read address (ARPROT ignored)
//  RREADY in 1; RVALID out 1; RDATA out 32; RRESP out 2          read data
//  tvalid/tdata/tkeep/tlast in 1/DATA_WIDTH/DATA_WIDTH/8/1; tready out 1   AXIS RX sink
// BEHAVIOUR
//  Reset: AWREADY=WREADY=BVALID=ARREADY=RVALID=0, BRESP=RRESP=2'b00, RDATA=0, tready=0, all regs 0.
//  Write: when AWVALID&&WVALID&&!BVALID, pulse AWREADY&WREADY 1 cycle, commit write (WSTRB per byte
//   on RW regs); BVALID next cycle, held until BREADY; BRESP always OKAY. One write in flight.
//  Read: when ARVALID&&!RVALID, pulse ARREADY 1 cycle; RVALID+RDATA next cycle, held stable until
//   RREADY; RRESP always OKAY. Unmapped/absent addresses read 0; writes to RO/unmapped ignored.
//  Register map (byte offsets):
//   0x00 CTRL rw: [0] rx_en; [1] cnt_clr write-1 self-clearing (reads 0)
//   0x04 STATUS ro: [0] rx_en; [1] in_packet; [2] pkt_seen (sticky, cleared by cnt_clr)
//   0x08 SCRATCH rw 32b;  0x0C ID ro = 32'hDA7A_0001
//   0x10 RX_PKT_CNT  ro: +1 per accepted beat with tlast
//   0x14 RX_BEAT_CNT ro: +1 per accepted beat
//   0x18 RX_BYTE_CNT ro: +popcount(tkeep) per accepted beat
//   0x1C LAST_LO / 0x20 LAST_HI ro: tdata[31:0]/[63:32] of last accepted beat (HI=0 if DATA_WIDTH=32)
//   0x24 RX_CSUM ro (see CONFIGURATION)
//  Stream: tready = rx_en (registered CTRL bit, no extra latency); accept = tvalid && tready.
//   in_packet sets on accepted non-last beat, clears on accepted tlast beat.
//  Counters 32-bit, saturate at 32'hFFFF_FFFF (no wrap). tkeep=0 beat counts beat, adds 0 bytes.
//  cnt_clr and accept in same cycle: clear wins, that beat is not counted; LAST_* still captured.
//  rx_en cleared mid-packet: tready drops next cycle, in_packet retained, counters hold.
//  Same-cycle AXIL read of a counter being updated returns pre-update value.
//  rst mid-transaction: all handshakes abort, outputs return to reset values next edge.
// CONFIGURATION
//  DP_RX_CSUM_EN defined: RX_CSUM = running XOR of all 32-bit lanes of every accepted beat in the
//   current packet, latched to RX_CSUM on tlast beat; accumulator resets after tlast and on cnt_clr.
//  Undefined: no checksum logic; 0x24 reads 0.
// TESTING
//  Reset, read 0x0C -> RDATA=32'hDA7A_0001, RRESP=0; read 0x00 -> 0; tready=0 with tvalid=1.
//  Write 0x08=32'h1234_5678 WSTRB=4'b0011, then WSTRB=4'b1100 data 32'hAABB_CCDD -> read 0xAABB_5678.
//  Write CTRL=1; send 3 beats tkeep=8'hFF, last beat tkeep=8'h0F tlast=1 -> PKT=1, BEAT=3, BYTE=20.
//  Hold BREADY/RREADY low 5 cycles -> BVALID/RVALID and RDATA stay stable; no second AWREADY.
//  Write CTRL=2'b11 during stream beat -> all counters 0, STATUS[2]=0; rx_en remains 1.
//  DP_RX_CSUM_EN: beat 64'h1_0000_0003 tlast -> RX_CSUM=32'h2; without macro -> 0x24 reads 0.

Source files
------------

// File: rtl/net_dataplane_top.sv
// net_dataplane_top
//   PL dataplane top. An AXI4-Lite slave register file gives the PS control, status and
//   statistics. An AXI-Stream RX sink consumes and counts ingress beats. The payload is
//   discarded except for a capture of the last accepted beat.
//
// Parameters
//   DATA_WIDTH       AXI-Stream tdata width (multiple of 8, >= 32); tkeep is DATA_WIDTH/8
//   AXIL_ADDR_WIDTH  AXI4-Lite address width (> 8); only bits [7:2] are decoded
//
// Ports
//   clk, rst                 system clock, synchronous active-high reset
//   AW*/W*/B*                AXI4-Lite write address, data and response channels
//   AR*/R*                   AXI4-Lite read address and data channels
//   tvalid/tdata/tkeep/tlast AXI-Stream RX sink inputs
//   tready                   AXI-Stream RX sink ready (equals CTRL.rx_en)
//
// Build option
//   DP_RX_CSUM_EN  when defined, RX_CSUM (0x24) holds the XOR of all 32-bit lanes of the
//                  last completed packet. When undefined, 0x24 reads 0.
//
// Register map (byte offsets)
//   0x00 CTRL (rw)        [0] rx_en, [1] cnt_clr (write-1 pulse, reads 0)
//   0x04 STATUS (ro)      [0] rx_en, [1] in_packet, [2] pkt_seen
//   0x08 SCRATCH (rw)     0x0C ID (ro) = 32'hDA7A_0001
//   0x10 RX_PKT_CNT       0x14 RX_BEAT_CNT   0x18 RX_BYTE_CNT  (saturating)
//   0x1C LAST_LO          0x20 LAST_HI       0x24 RX_CSUM
module net_dataplane_top #(
    parameter int DATA_WIDTH      = 64,
    parameter int AXIL_ADDR_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic [AXIL_ADDR_WIDTH-1:0] AWADDR,
    input  logic [2:0]                 AWPROT,
    input  logic                       AWVALID,
    output logic                       AWREADY,
    input  logic [31:0]                WDATA,
    input  logic [3:0]                 WSTRB,
    input  logic                       WVALID,
    output logic                       WREADY,
    input  logic                       BREADY,
    output logic                       BVALID,
    output logic [1:0]                 BRESP,

    input  logic [AXIL_ADDR_WIDTH-1:0] ARADDR,
    input  logic [2:0]                 ARPROT,
    input  logic                       ARVALID,
    output logic                       ARREADY,
    input  logic                       RREADY,
    output logic                       RVALID,
    output logic [31:0]                RDATA,
    output logic [1:0]                 RRESP,

    input  logic                       tvalid,
    input  logic [DATA_WIDTH-1:0]      tdata,
    input  logic [DATA_WIDTH/8-1:0]    tkeep,
    input  logic                       tlast,
    output logic                       tready
);

    localparam int          KEEP_W = DATA_WIDTH / 8;
    localparam logic [31:0] ID_VAL = 32'hDA7A_0001;

    function automatic logic [31:0] popcount(input logic [KEEP_W-1:0] v);
        logic [31:0] n;
        n = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            n = n + {31'd0, v[i]};
        end
        return n;
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    logic        aw_ready_q, b_valid_q, ar_ready_q, r_valid_q;
    logic [31:0] r_data_q;
    logic        rx_en_q, in_packet_q, pkt_seen_q;
    logic [31:0] scratch_q, pkt_cnt_q, beat_cnt_q, byte_cnt_q, last_lo_q, last_hi_q;
    logic [31:0] beat_hi;
    logic [31:0] rd_mux;
    logic [5:0]  wr_idx, rd_idx;
    logic        wr_fire, rd_fire, accept, cnt_clr;
    logic        unused_bits;

    assign wr_idx  = AWADDR[7:2];
    assign rd_idx  = ARADDR[7:2];
    // aw_ready_q is only ever high for one cycle, so a fire means exactly one write commits.
    assign wr_fire = aw_ready_q && AWVALID && WVALID;
    assign rd_fire = ar_ready_q && ARVALID;
    assign accept  = tvalid && rx_en_q;
    assign cnt_clr = wr_fire && (wr_idx == 6'd0) && WSTRB[0] && WDATA[1];

    assign AWREADY = aw_ready_q;
    assign WREADY  = aw_ready_q;
    assign BVALID  = b_valid_q;
    assign BRESP   = 2'b00;
    assign ARREADY = ar_ready_q;
    assign RVALID  = r_valid_q;
    assign RDATA   = r_data_q;
    assign RRESP   = 2'b00;
    assign tready  = rx_en_q;

    assign unused_bits = ^{AWPROT, ARPROT, AWADDR[1:0], ARADDR[1:0],
                           AWADDR[AXIL_ADDR_WIDTH-1:8], ARADDR[AXIL_ADDR_WIDTH-1:8], tdata};

    generate
        if (DATA_WIDTH >= 64) begin : g_last_hi
            assign beat_hi = tdata[63:32];
        end else begin : g_no_last_hi
            assign beat_hi = 32'd0;
        end
    endgenerate

`ifdef DP_RX_CSUM_EN
    localparam int LANES = (DATA_WIDTH + 31) / 32;
    logic [LANES*32-1:0] tdata_pad;
    logic [31:0]         beat_xor, csum_acc_q, csum_q;

    always_comb begin
        tdata_pad                   = '0;
        tdata_pad[DATA_WIDTH-1:0]   = tdata;
        beat_xor                    = '0;
        for (int i = 0; i < LANES; i++) begin
            beat_xor = beat_xor ^ tdata_pad[i*32 +: 32];
        end
    end

    // A tlast beat folds into the latched result directly, so the accumulator only ever
    // holds the open portion of the current packet.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            csum_acc_q <= '0;
            csum_q     <= '0;
        end else if (accept) begin
            if (tlast) begin
                csum_q     <= csum_acc_q ^ beat_xor;
                csum_acc_q <= '0;
            end else begin
                csum_acc_q <= csum_acc_q ^ beat_xor;
            end
        end
    end
`endif

    always_comb begin
        rd_mux = 32'd0;
        case (rd_idx)
            6'd0: rd_mux = {31'd0, rx_en_q};
            6'd1: rd_mux = {29'd0, pkt_seen_q, in_packet_q, rx_en_q};
            6'd2: rd_mux = scratch_q;
            6'd3: rd_mux = ID_VAL;
            6'd4: rd_mux = pkt_cnt_q;
            6'd5: rd_mux = beat_cnt_q;
            6'd6: rd_mux = byte_cnt_q;
            6'd7: rd_mux = last_lo_q;
            6'd8: rd_mux = last_hi_q;
`ifdef DP_RX_CSUM_EN
            6'd9: rd_mux = csum_q;
`endif
            default: rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_ready_q <= 1'b0;
            b_valid_q  <= 1'b0;
            ar_ready_q <= 1'b0;
            r_valid_q  <= 1'b0;
            r_data_q   <= '0;
        end else begin
            aw_ready_q <= AWVALID && WVALID && !b_valid_q && !aw_ready_q;
            if (wr_fire) begin
                b_valid_q <= 1'b1;
            end else if (BREADY) begin
                b_valid_q <= 1'b0;
            end

            ar_ready_q <= ARVALID && !r_valid_q && !ar_ready_q;
            // Sampling rd_mux here returns counter values from before this edge's update.
            if (rd_fire) begin
                r_valid_q <= 1'b1;
                r_data_q  <= rd_mux;
            end else if (RREADY) begin
                r_valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_en_q     <= 1'b0;
            scratch_q   <= '0;
            in_packet_q <= 1'b0;
            pkt_seen_q  <= 1'b0;
            pkt_cnt_q   <= '0;
            beat_cnt_q  <= '0;
            byte_cnt_q  <= '0;
            last_lo_q   <= '0;
            last_hi_q   <= '0;
        end else begin
            if (wr_fire && (wr_idx == 6'd0) && WSTRB[0]) begin
                rx_en_q <= WDATA[0];
            end
            if (wr_fire && (wr_idx == 6'd2)) begin
                for (int b = 0; b < 4; b++) begin
                    if (WSTRB[b]) begin
                        scratch_q[b*8 +: 8] <= WDATA[b*8 +: 8];
                    end
                end
            end

            if (accept) begin
                last_lo_q   <= tdata[31:0];
                last_hi_q   <= beat_hi;
                in_packet_q <= !tlast;
            end

            // A clear in the same cycle as an accept wins; that beat goes uncounted.
            if (cnt_clr) begin
                pkt_cnt_q  <= '0;
                beat_cnt_q <= '0;
                byte_cnt_q <= '0;
                pkt_seen_q <= 1'b0;
            end else if (accept) begin
                beat_cnt_q <= sat_add(beat_cnt_q, 32'd1);
                byte_cnt_q <= sat_add(byte_cnt_q, popcount(tkeep));
                if (tlast) begin
                    pkt_cnt_q  <= sat_add(pkt_cnt_q, 32'd1);
                    pkt_seen_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_net_dataplane_top.sv
module tb_net_dataplane_top;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] AWADDR, ARADDR, WDATA;
    logic [2:0]  AWPROT, ARPROT;
    logic [3:0]  WSTRB;
    logic        AWVALID, WVALID, BREADY, ARVALID, RREADY;
    logic        AWREADY, WREADY, BVALID, ARREADY, RVALID;
    logic [1:0]  BRESP, RRESP;
    logic [31:0] RDATA;
    logic        tvalid, tlast, tready;
    logic [63:0] tdata;
    logic [7:0]  tkeep;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    net_dataplane_top #(.DATA_WIDTH(64), .AXIL_ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BREADY(BREADY), .BVALID(BVALID), .BRESP(BRESP),
        .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RREADY(RREADY), .RVALID(RVALID), .RDATA(RDATA), .RRESP(RRESP),
        .tvalid(tvalid), .tdata(tdata), .tkeep(tkeep), .tlast(tlast), .tready(tready)
    );

    task automatic wait_awready();
        int n = 0;
        while (AWREADY !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) begin
            checks++; errors++;
            $display("FAIL awready_timeout: got %b required 1", AWREADY);
        end
    endtask

    task automatic wait_arready();
        int n = 0;
        while (ARREADY !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) begin
            checks++; errors++;
            $display("FAIL arready_timeout: got %b required 1", ARREADY);
        end
    endtask

    task automatic axil_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        AWADDR = addr; WDATA = data; WSTRB = strb;
        AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
        wait_awready();
        @(posedge clk); #1;
        AWVALID = 1'b0; WVALID = 1'b0;
        checks++;
        if (BVALID !== 1'b1 || BRESP !== 2'b00) begin
            errors++;
            $display("FAIL wr_bresp addr %h: got bvalid=%b bresp=%b required 1/00", addr, BVALID, BRESP);
        end
        @(posedge clk); #1;
    endtask

    task automatic axil_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        ARADDR = addr; ARVALID = 1'b1; RREADY = 1'b1;
        wait_arready();
        @(posedge clk); #1;
        ARVALID = 1'b0;
        data = RDATA;
        resp = RRESP;
        checks++;
        if (RVALID !== 1'b1) begin
            errors++;
            $display("FAIL rd_rvalid addr %h: got %b required 1", addr, RVALID);
        end
        @(posedge clk); #1;
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        tvalid = 1'b1; tdata = d; tkeep = k; tlast = l;
        @(posedge clk); #1;
        tvalid = 1'b0; tlast = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic [1:0]  rr;
        rst = 1'b1;
        AWADDR = '0; ARADDR = '0; WDATA = '0; AWPROT = '0; ARPROT = '0; WSTRB = '0;
        AWVALID = 0; WVALID = 0; BREADY = 0; ARVALID = 0; RREADY = 0;
        tvalid = 1'b1; tdata = 64'h0; tkeep = 8'hFF; tlast = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if ({AWREADY, WREADY, BVALID, ARREADY, RVALID} !== 5'b0 || BRESP !== 2'b00 ||
            RRESP !== 2'b00 || RDATA !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: got aw%b w%b b%b ar%b r%b bresp%b rresp%b rdata %h required all 0",
                     AWREADY, WREADY, BVALID, ARREADY, RVALID, BRESP, RRESP, RDATA);
        end
        checks++;
        if (tready !== 1'b0) begin
            errors++;
            $display("FAIL reset_tready: got %b required 0", tready);
        end
        @(posedge clk); #1;
        tvalid = 1'b0;
        axil_read(32'h0C, rd, rr);
        checks++;
        if (rd !== 32'hDA7A_0001 || rr !== 2'b00) begin
            errors++;
            $display("FAIL id_read: got %h/%b required DA7A0001/00", rd, rr);
        end
        axil_read(32'h00, rd, rr);
        checks++;
        if (rd !== 32'd0) begin
            errors++;
            $display("FAIL ctrl_reset: got %h required 0", rd);
        end
    endtask

    task automatic test_scratch();
        logic [31:0] rd;
        logic [1:0]  rr;
        axil_write(32'h08, 32'h1234_5678, 4'b0011);
        axil_write(32'h08, 32'hAABB_CCDD, 4'b1100);
        axil_read(32'h08, rd, rr);
        checks++;
        if (rd !== 32'hAABB_5678) begin
            errors++;
            $display("FAIL scratch_wstrb: got %h required AABB5678", rd);
        end
        axil_write(32'h0C, 32'hFFFF_FFFF, 4'hF);
        axil_read(32'h0C, rd, rr);
        checks++;
        if (rd !== 32'hDA7A_0001) begin
            errors++;
            $display("FAIL id_ro: got %h required DA7A0001", rd);
        end
        axil_write(32'h28, 32'h1111_1111, 4'hF);
        axil_read(32'h28, rd, rr);
        checks++;
        if (rd !== 32'd0 || rr !== 2'b00) begin
            errors++;
            $display("FAIL unmapped_read: got %h/%b required 0/00", rd, rr);
        end
    endtask

    task automatic test_stream();
        logic [31:0] rd;
        logic [1:0]  rr;
        axil_write(32'h00, 32'h1, 4'h1);
        checks++;
        if (tready !== 1'b1) begin
            errors++;
            $display("FAIL tready_en: got %b required 1", tready);
        end
        send_beat(64'h0123_4567_89AB_CDEF, 8'hFF, 1'b0);
        axil_read(32'h04, rd, rr);
        checks++;
        if (rd !== 32'h3) begin
            errors++;
            $display("FAIL status_in_pkt: got %h required 3", rd);
        end
        send_beat(64'h1111_2222_3333_4444, 8'hFF, 1'b0);
        send_beat(64'hDEAD_BEEF_CAFE_F00D, 8'h0F, 1'b1);
        axil_read(32'h10, rd, rr);
        checks++;
        if (rd !== 32'd1) begin errors++; $display("FAIL pkt_cnt: got %0d required 1", rd); end
        axil_read(32'h14, rd, rr);
        checks++;
        if (rd !== 32'd3) begin errors++; $display("FAIL beat_cnt: got %0d required 3", rd); end
        axil_read(32'h18, rd, rr);
        checks++;
        if (rd !== 32'd20) begin errors++; $display("FAIL byte_cnt: got %0d required 20", rd); end
        axil_read(32'h1C, rd, rr);
        checks++;
        if (rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL last_lo: got %h required CAFEF00D", rd); end
        axil_read(32'h20, rd, rr);
        checks++;
        if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL last_hi: got %h required DEADBEEF", rd); end
        axil_read(32'h04, rd, rr);
        checks++;
        if (rd !== 32'h5) begin errors++; $display("FAIL status_pkt_seen: got %h required 5", rd); end
        send_beat(64'h0, 8'h00, 1'b1);
        axil_read(32'h14, rd, rr);
        checks++;
        if (rd !== 32'd4) begin errors++; $display("FAIL beat_cnt_keep0: got %0d required 4", rd); end
        axil_read(32'h18, rd, rr);
        checks++;
        if (rd !== 32'd20) begin errors++; $display("FAIL byte_cnt_keep0: got %0d required 20", rd); end
        axil_read(32'h10, rd, rr);
        checks++;
        if (rd !== 32'd2) begin errors++; $display("FAIL pkt_cnt_keep0: got %0d required 2", rd); end
    endtask

    task automatic test_back_to_back();
        AWADDR = 32'h08; WDATA = 32'h5A5A_A5A5; WSTRB = 4'hF;
        AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b0;
        wait_awready();
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (BVALID !== 1'b1 || AWREADY !== 1'b0 || BRESP !== 2'b00) begin
                errors++;
                $display("FAIL bvalid_hold cyc %0d: got bvalid=%b awready=%b required 1/0", i, BVALID, AWREADY);
            end
            @(posedge clk); #1;
        end
        AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (BVALID !== 1'b0) begin errors++; $display("FAIL bvalid_release: got %b required 0", BVALID); end

        ARADDR = 32'h08; ARVALID = 1'b1; RREADY = 1'b0;
        wait_arready();
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (RVALID !== 1'b1 || ARREADY !== 1'b0 || RDATA !== 32'h5A5A_A5A5) begin
                errors++;
                $display("FAIL rvalid_hold cyc %0d: got rvalid=%b arready=%b rdata=%h required 1/0/5A5AA5A5",
                         i, RVALID, ARREADY, RDATA);
            end
            @(posedge clk); #1;
        end
        ARVALID = 1'b0; RREADY = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (RVALID !== 1'b0) begin errors++; $display("FAIL rvalid_release: got %b required 0", RVALID); end
    endtask

    task automatic test_read_during_update();
        logic [31:0] rd;
        logic [1:0]  rr;
        ARADDR = 32'h14; ARVALID = 1'b1; RREADY = 1'b1;
        wait_arready();
        tvalid = 1'b1; tdata = 64'h5555_6666_7777_8888; tkeep = 8'hFF; tlast = 1'b0;
        @(posedge clk); #1;
        tvalid = 1'b0; ARVALID = 1'b0;
        checks++;
        if (RVALID !== 1'b1 || RDATA !== 32'd4) begin
            errors++;
            $display("FAIL read_pre_update: got rvalid=%b rdata=%0d required 1/4", RVALID, RDATA);
        end
        @(posedge clk); #1;
        axil_read(32'h14, rd, rr);
        checks++;
        if (rd !== 32'd5) begin errors++; $display("FAIL beat_cnt_post: got %0d required 5", rd); end
        axil_read(32'h04, rd, rr);
        checks++;
        if (rd !== 32'h7) begin errors++; $display("FAIL status_all: got %h required 7", rd); end
    endtask

    task automatic test_clear();
        logic [31:0] rd;
        logic [1:0]  rr;
        AWADDR = 32'h00; WDATA = 32'h3; WSTRB = 4'h1;
        AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
        wait_awready();
        tvalid = 1'b1; tdata = 64'h0000_0077_0000_0066; tkeep = 8'hFF; tlast = 1'b1;
        @(posedge clk); #1;
        tvalid = 1'b0; tlast = 1'b0; AWVALID = 1'b0; WVALID = 1'b0;
        @(posedge clk); #1;
        axil_read(32'h10, rd, rr);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL clr_pkt: got %0d required 0", rd); end
        axil_read(32'h14, rd, rr);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL clr_beat: got %0d required 0", rd); end
        axil_read(32'h18, rd, rr);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL clr_byte: got %0d required 0", rd); end
        axil_read(32'h04, rd, rr);
        checks++;
        if (rd !== 32'h1) begin errors++; $display("FAIL clr_status: got %h required 1", rd); end
        axil_read(32'h1C, rd, rr);
        checks++;
        if (rd !== 32'h66) begin errors++; $display("FAIL clr_last_lo: got %h required 66", rd); end
        axil_read(32'h00, rd, rr);
        checks++;
        if (rd !== 32'h1) begin errors++; $display("FAIL clr_ctrl: got %h required 1", rd); end
        send_beat(64'h0000_0000_0000_ABCD, 8'h03, 1'b1);
        axil_read(32'h18, rd, rr);
        checks++;
        if (rd !== 32'd2) begin errors++; $display("FAIL resume_byte: got %0d required 2", rd); end
        axil_read(32'h10, rd, rr);
        checks++;
        if (rd !== 32'd1) begin errors++; $display("FAIL resume_pkt: got %0d required 1", rd); end
    endtask

    task automatic test_rx_disable();
        logic [31:0] rd;
        logic [1:0]  rr;
        send_beat(64'h1, 8'hFF, 1'b0);
        axil_write(32'h00, 32'h0, 4'h1);
        checks++;
        if (tready !== 1'b0) begin errors++; $display("FAIL tready_dis: got %b required 0", tready); end
        tvalid = 1'b1; tdata = 64'h2; tkeep = 8'hFF; tlast = 1'b1;
        repeat (3) @(posedge clk);
        #1 tvalid = 1'b0; tlast = 1'b0;
        axil_read(32'h14, rd, rr);
        checks++;
        if (rd !== 32'd2) begin errors++; $display("FAIL dis_beat: got %0d required 2", rd); end
        axil_read(32'h04, rd, rr);
        checks++;
        if (rd !== 32'h6) begin errors++; $display("FAIL dis_status: got %h required 6", rd); end
    endtask

    task automatic test_csum();
        logic [31:0] rd;
        logic [1:0]  rr;
        logic [31:0] exp_csum;
`ifdef DP_RX_CSUM_EN
        exp_csum = 32'h2;
`else
        exp_csum = 32'h0;
`endif
        axil_write(32'h00, 32'h3, 4'h1);
        send_beat(64'h0000_0001_0000_0003, 8'hFF, 1'b1);
        axil_read(32'h24, rd, rr);
        checks++;
        if (rd !== exp_csum) begin errors++; $display("FAIL rx_csum: got %h required %h", rd, exp_csum); end
        axil_read(32'h10, rd, rr);
        checks++;
        if (rd !== 32'd1) begin errors++; $display("FAIL csum_pkt: got %0d required 1", rd); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic [1:0]  rr;
        ARADDR = 32'h0C; ARVALID = 1'b1; RREADY = 1'b0;
        wait_arready();
        @(posedge clk); #1;
        ARVALID = 1'b0;
        checks++;
        if (RVALID !== 1'b1) begin errors++; $display("FAIL mid_rvalid: got %b required 1", RVALID); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (RVALID !== 1'b0 || RDATA !== 32'd0 || ARREADY !== 1'b0 || BVALID !== 1'b0 || tready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got rvalid=%b rdata=%h arready=%b bvalid=%b tready=%b required all 0",
                     RVALID, RDATA, ARREADY, BVALID, tready);
        end
        RREADY = 1'b1;
        axil_read(32'h08, rd, rr);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL mid_scratch: got %h required 0", rd); end
        axil_read(32'h10, rd, rr);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL mid_pkt: got %0d required 0", rd); end
    endtask

    initial begin
        test_reset();
        test_scratch();
        test_stream();
        test_back_to_back();
        test_read_during_update();
        test_clear();
        test_rx_disable();
        test_csum();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1, "watchdog");
    end

endmodule
